// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - operand forwarding, load-use/scoreboard stall detection and stall watchdog
module fwd_hazard_unit #(
    parameter int XLEN      = 32,
    parameter int NUM_SRC   = 2,
    parameter int NUM_FWD   = 2,
    parameter int MAX_STALL = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC-1:0]        src_valid,
    input  logic [NUM_SRC*5-1:0]      src_reg,
    input  logic [NUM_SRC*XLEN-1:0]   rf_data,
    input  logic [NUM_FWD-1:0]        stg_ld_regfile,
    input  logic [NUM_FWD*5-1:0]      stg_dest,
    input  logic [NUM_FWD*XLEN-1:0]   stg_data,
    input  logic [NUM_FWD-1:0]        stg_ready,
    input  logic                      lat_issue,
    input  logic [4:0]                lat_rd,
    input  logic                      lat_done,
    input  logic [4:0]                lat_done_rd,
    output logic [NUM_SRC*XLEN-1:0]   opnd_data,
    output logic [NUM_SRC-1:0]        opnd_fwd,
    output logic                      stall,
    output logic [31:0]               sb_busy,
    output logic [31:0]               stall_cycles,
    output logic                      sb_conflict,
    output logic                      deadlock
);

    typedef enum logic {RUN, HOLD} state_t;

    state_t      state;
    logic [31:0] streak;

    logic [4:0]      cur_reg;
    logic            hit;
    logic            hit_ready;
    logic [XLEN-1:0] hit_data;

    // Stages are scanned oldest to youngest so the youngest match wins.
    always_comb begin
        opnd_data = '0;
        opnd_fwd  = '0;
        stall     = 1'b0;
        cur_reg   = '0;
        hit       = 1'b0;
        hit_ready = 1'b0;
        hit_data  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            cur_reg   = src_reg[i*5 +: 5];
            hit       = 1'b0;
            hit_ready = 1'b0;
            hit_data  = '0;
            for (int k = NUM_FWD - 1; k >= 0; k--) begin
                if (stg_ld_regfile[k] && (stg_dest[k*5 +: 5] == cur_reg)) begin
                    hit       = 1'b1;
                    hit_ready = stg_ready[k];
                    hit_data  = stg_data[k*XLEN +: XLEN];
                end
            end
            if (cur_reg == 5'd0) begin
                opnd_data[i*XLEN +: XLEN] = '0;
                opnd_fwd[i]               = 1'b0;
            end else if (hit) begin
                if (hit_ready) begin
                    opnd_data[i*XLEN +: XLEN] = hit_data;
                    opnd_fwd[i]               = 1'b1;
                end else begin
                    // Load-use: the youngest match is not ready, older stages hold stale values.
                    opnd_data[i*XLEN +: XLEN] = rf_data[i*XLEN +: XLEN];
                    if (src_valid[i]) begin
                        stall = 1'b1;
                    end
                end
            end else begin
                opnd_data[i*XLEN +: XLEN] = rf_data[i*XLEN +: XLEN];
                if (src_valid[i] && sb_busy[cur_reg]) begin
                    stall = 1'b1;
                end
            end
        end
    end

    logic [31:0] sb_next;
    logic        issue_ok;
    logic        same_done;

    always_comb begin
        issue_ok  = lat_issue && (lat_rd != 5'd0);
        same_done = lat_done && (lat_done_rd == lat_rd);
        sb_next   = sb_busy;
        if (lat_done) begin
            sb_next[lat_done_rd] = 1'b0;
        end
        if (issue_ok) begin
            sb_next[lat_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_busy      <= '0;
            sb_conflict  <= 1'b0;
            stall_cycles <= '0;
            streak       <= '0;
            deadlock     <= 1'b0;
            state        <= RUN;
        end else begin
            sb_busy <= sb_next;
            if (issue_ok && sb_busy[lat_rd] && !same_done) begin
                sb_conflict <= 1'b1;
            end
            if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            case (state)
                RUN: begin
                    streak <= '0;
                    state  <= stall ? HOLD : RUN;
                end
                HOLD: begin
                    if (stall) begin
                        if (streak < 32'(MAX_STALL)) begin
                            streak <= streak + 32'd1;
                        end
                        if (streak + 32'd1 >= 32'(MAX_STALL)) begin
                            deadlock <= 1'b1;
                        end
                        state <= HOLD;
                    end else begin
                        streak <= '0;
                        state  <= RUN;
                    end
                end
                default: begin
                    streak <= '0;
                    state  <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - directed self-checking bench for fwd_hazard_unit
module tb_fwd_hazard_unit;

    localparam int XLEN      = 32;
    localparam int NUM_SRC   = 2;
    localparam int NUM_FWD   = 2;
    localparam int MAX_STALL = 8;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_SRC-1:0]      src_valid;
    logic [NUM_SRC*5-1:0]    src_reg;
    logic [NUM_SRC*XLEN-1:0] rf_data;
    logic [NUM_FWD-1:0]      stg_ld_regfile;
    logic [NUM_FWD*5-1:0]    stg_dest;
    logic [NUM_FWD*XLEN-1:0] stg_data;
    logic [NUM_FWD-1:0]      stg_ready;
    logic                    lat_issue;
    logic [4:0]              lat_rd;
    logic                    lat_done;
    logic [4:0]              lat_done_rd;
    logic [NUM_SRC*XLEN-1:0] opnd_data;
    logic [NUM_SRC-1:0]      opnd_fwd;
    logic                    stall;
    logic [31:0]             sb_busy;
    logic [31:0]             stall_cycles;
    logic                    sb_conflict;
    logic                    deadlock;

    int n_cmp = 0;
    int n_err = 0;

    fwd_hazard_unit #(
        .XLEN(XLEN), .NUM_SRC(NUM_SRC), .NUM_FWD(NUM_FWD), .MAX_STALL(MAX_STALL)
    ) dut (
        .clk(clk), .rst(rst),
        .src_valid(src_valid), .src_reg(src_reg), .rf_data(rf_data),
        .stg_ld_regfile(stg_ld_regfile), .stg_dest(stg_dest),
        .stg_data(stg_data), .stg_ready(stg_ready),
        .lat_issue(lat_issue), .lat_rd(lat_rd),
        .lat_done(lat_done), .lat_done_rd(lat_done_rd),
        .opnd_data(opnd_data), .opnd_fwd(opnd_fwd), .stall(stall),
        .sb_busy(sb_busy), .stall_cycles(stall_cycles),
        .sb_conflict(sb_conflict), .deadlock(deadlock)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        src_valid      = '0;
        src_reg        = '0;
        rf_data        = '0;
        stg_ld_regfile = '0;
        stg_dest       = '0;
        stg_data       = '0;
        stg_ready      = '0;
        lat_issue      = 1'b0;
        lat_rd         = '0;
        lat_done       = 1'b0;
        lat_done_rd    = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        clear_inputs();
        do_reset();
        check("rst_sb_busy", 64'(sb_busy), 64'h0);
        check("rst_stall_cycles", 64'(stall_cycles), 64'h0);
        check("rst_conflict", 64'(sb_conflict), 64'h0);
        check("rst_deadlock", 64'(deadlock), 64'h0);
        check("rst_stall", 64'(stall), 64'h0);

        // Youngest-stage priority, second operand from regfile
        stg_ld_regfile = 2'b11;
        stg_dest       = {5'd5, 5'd5};
        stg_data       = {32'hBBBB, 32'hAAAA};
        stg_ready      = 2'b11;
        src_valid      = 2'b11;
        src_reg        = {5'd3, 5'd5};
        rf_data        = {32'h33, 32'h1111};
        #1;
        check("prio_data0", 64'(opnd_data[31:0]), 64'hAAAA);
        check("prio_fwd0", 64'(opnd_fwd[0]), 64'h1);
        check("rf_data1", 64'(opnd_data[63:32]), 64'h33);
        check("rf_fwd1", 64'(opnd_fwd[1]), 64'h0);
        check("prio_stall", 64'(stall), 64'h0);

        // Load-use in youngest stage masks a ready older stage
        clear_inputs();
        stg_ld_regfile = 2'b11;
        stg_dest       = {5'd7, 5'd7};
        stg_data       = {32'h5555, 32'h0};
        stg_ready      = 2'b10;
        src_valid      = 2'b10;
        src_reg        = {5'd7, 5'd0};
        #1;
        check("lu_older_ignored", 64'(stall), 64'h1);
        stg_ld_regfile = 2'b01;
        #1;
        check("lu_stall", 64'(stall), 64'h1);
        src_valid = 2'b00;
        #1;
        check("lu_invalid_nostall", 64'(stall), 64'h0);
        src_valid = 2'b10;
        tick();
        stg_ld_regfile = 2'b10;
        stg_dest       = {5'd7, 5'd0};
        stg_data       = {32'h1234, 32'h0};
        stg_ready      = 2'b10;
        #1;
        check("lu_release_stall", 64'(stall), 64'h0);
        check("lu_release_data1", 64'(opnd_data[63:32]), 64'h1234);
        check("lu_release_fwd1", 64'(opnd_fwd[1]), 64'h1);
        check("lu_stall_cycles", 64'(stall_cycles), 64'h1);

        // x0 is never forwarded nor stalled
        clear_inputs();
        stg_ld_regfile = 2'b01;
        stg_dest       = {5'd0, 5'd0};
        stg_data       = {32'h0, 32'hFFFF_FFFF};
        stg_ready      = 2'b00;
        src_valid      = 2'b01;
        rf_data        = {32'h0, 32'hDEAD};
        #1;
        check("x0_data", 64'(opnd_data[31:0]), 64'h0);
        check("x0_fwd", 64'(opnd_fwd[0]), 64'h0);
        check("x0_stall", 64'(stall), 64'h0);

        // Scoreboard stall on a mul/div result
        clear_inputs();
        do_reset();
        lat_issue = 1'b1;
        lat_rd    = 5'd9;
        src_reg   = {5'd0, 5'd9};
        #1;
        check("sb_not_yet_busy", 64'(stall), 64'h0);
        tick();
        lat_issue = 1'b0;
        check("sb_set", 64'(sb_busy), 64'h200);
        check("sb_invalid_nostall", 64'(stall), 64'h0);
        src_valid = 2'b01;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("sb_stall_%0d", c), 64'(stall), 64'h1);
            tick();
        end
        lat_done    = 1'b1;
        lat_done_rd = 5'd9;
        #1;
        check("sb_done_cycle_stall", 64'(stall), 64'h1);
        tick();
        lat_done = 1'b0;
        check("sb_released", 64'(stall), 64'h0);
        check("sb_cleared", 64'(sb_busy), 64'h0);
        check("sb_stall_cycles", 64'(stall_cycles), 64'h4);
        // Stage match overrides a busy scoreboard bit
        clear_inputs();
        lat_issue = 1'b1;
        lat_rd    = 5'd9;
        tick();
        lat_issue      = 1'b0;
        src_valid      = 2'b01;
        src_reg        = {5'd0, 5'd9};
        stg_ld_regfile = 2'b10;
        stg_dest       = {5'd9, 5'd0};
        stg_data       = {32'h99, 32'h0};
        stg_ready      = 2'b10;
        #1;
        check("stage_over_sb_stall", 64'(stall), 64'h0);
        check("stage_over_sb_data", 64'(opnd_data[31:0]), 64'h99);

        // Conflict detection
        clear_inputs();
        do_reset();
        lat_issue = 1'b1;
        lat_rd    = 5'd4;
        tick();
        check("conf_first", 64'(sb_conflict), 64'h0);
        tick();
        lat_issue = 1'b0;
        check("conf_second", 64'(sb_conflict), 64'h1);
        tick();
        check("conf_sticky", 64'(sb_conflict), 64'h1);
        do_reset();
        lat_issue = 1'b1;
        lat_rd    = 5'd4;
        tick();
        lat_done    = 1'b1;
        lat_done_rd = 5'd4;
        tick();
        clear_inputs();
        check("same_cycle_busy", 64'(sb_busy), 64'h10);
        check("same_cycle_noconf", 64'(sb_conflict), 64'h0);
        lat_issue = 1'b1;
        lat_rd    = 5'd0;
        lat_done    = 1'b1;
        lat_done_rd = 5'd6;
        tick();
        clear_inputs();
        check("x0_issue_ignored", 64'(sb_busy), 64'h10);
        check("x0_issue_noconf", 64'(sb_conflict), 64'h0);

        // Watchdog: deadlock after a long scoreboard stall
        do_reset();
        lat_issue = 1'b1;
        lat_rd    = 5'd9;
        tick();
        lat_issue = 1'b0;
        src_valid = 2'b01;
        src_reg   = {5'd0, 5'd9};
        for (int c = 0; c < MAX_STALL - 1; c++) tick();
        check("dl_not_yet", 64'(deadlock), 64'h0);
        tick();
        tick();
        check("dl_set", 64'(deadlock), 64'h1);
        check("dl_stall_cycles", 64'(stall_cycles), 64'(MAX_STALL + 1));
        rst       = 1'b1;
        lat_issue = 1'b1;
        lat_rd    = 5'd12;
        tick();
        rst       = 1'b0;
        lat_issue = 1'b0;
        check("rst2_sb_busy", 64'(sb_busy), 64'h0);
        check("rst2_stall_cycles", 64'(stall_cycles), 64'h0);
        check("rst2_deadlock", 64'(deadlock), 64'h0);
        check("rst2_conflict", 64'(sb_conflict), 64'h0);
        check("rst2_stall", 64'(stall), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 Parameter XLEN, default 32, datapath width in bits.
REQ-002 Parameter NUM_SRC, default 2, number of source operands resolved per cycle (1..4).
REQ-003 Parameter NUM_FWD, default 2, number of forwarding stages; index 0 is the youngest stage (EX/MEM) (1..4).
REQ-004 Parameter MAX_STALL, default 64, watchdog limit on consecutive stall cycles (>=2).
REQ-005 clk  in  1  the single clock; all state changes on the rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 src_valid  in  NUM_SRC  operand i is consumed this cycle.
REQ-008 src_reg  in  NUM_SRC*5  architectural source register of operand i.
REQ-009 rf_data  in  NUM_SRC*XLEN  register-file read value of operand i.
REQ-010 stg_ld_regfile  in  NUM_FWD  stage k will write the regfile.
REQ-011 stg_dest  in  NUM_FWD*5  destination register of stage k.
REQ-012 stg_data  in  NUM_FWD*XLEN  final result of stage k (ALU, br_en, or MDR already muxed).
REQ-013 stg_ready  in  NUM_FWD  stg_data of stage k is valid this cycle (0 for a load awaiting memory).
REQ-014 lat_issue / lat_rd  in  1 / 5  a long-latency op (mul/div) targeting lat_rd issues this cycle.
REQ-015 lat_done / lat_done_rd  in  1 / 5  the long-latency op for lat_done_rd completes this cycle.
REQ-016 opnd_data  out  NUM_SRC*XLEN  resolved operand value.
REQ-017 opnd_fwd  out  NUM_SRC  operand i came from a forwarding stage.
REQ-018 stall  out  1  hold the ID/EX boundary this cycle.
REQ-019 sb_busy  out  32  registered pending-write bitmap.
REQ-020 stall_cycles  out  32  saturating count of stalled cycles.
REQ-021 sb_conflict, deadlock  out  1 each  sticky error flags.

Function
REQ-022 Per operand i, a stage k matches when stg_ld_regfile[k]=1, stg_dest[k]=src_reg[i], and src_reg[i]!=0; the lowest matching k is selected.
REQ-023 src_reg[i]=0 yields opnd_data=0, opnd_fwd=0, and no stall contribution, regardless of stage or scoreboard state.
REQ-024 Selected stage with stg_ready=1: opnd_data=stg_data[k], opnd_fwd=1; no match: opnd_data=rf_data[i], opnd_fwd=0; combinational, zero latency.
REQ-025 Selected stage with stg_ready=0 (load-use) and src_valid[i]=1 raises stall; older matching stages are not consulted.
REQ-026 src_valid[i]=1, no stage match, and sb_busy[src_reg[i]]=1 raises stall; a stage match takes priority over the scoreboard.
REQ-027 stall is the combinational OR over all operands of REQ-025/026; src_valid[i]=0 operands never stall.
REQ-028 Scoreboard update at clock edge: lat_done clears bit lat_done_rd, then lat_issue sets bit lat_rd; same register in the same cycle leaves the bit 1.
REQ-029 lat_issue with lat_rd=0 is ignored; lat_done on a clear bit is ignored.
REQ-030 lat_issue to an already-set bit (not cleared the same cycle) sets sb_conflict; it stays 1 until reset.
REQ-031 The stall decision uses registered sb_busy only; a completion clears the stall from the next cycle.
REQ-032 FSM states RUN and HOLD; RUN->HOLD when stall=1; HOLD->RUN when stall=0; the state is exposed only via the counters.
REQ-033 stall_cycles increments each cycle stall=1, saturating at 2^32-1.
REQ-034 streak counter: increments each HOLD cycle with stall=1 and zeroes on RUN; reaching MAX_STALL sets deadlock, sticky until reset.

Reset
REQ-035 rst=1 at an edge clears sb_busy, stall_cycles, streak, sb_conflict, and deadlock, and sets state RUN; rst overrides lat_issue/lat_done in that cycle.
REQ-036 During and after reset, combinational outputs follow inputs using the cleared scoreboard; reset mid-stall releases stall next cycle unless a stage hazard persists.

Verification
REQ-037 Stage0 dest=x5 data=0xAAAA ready=1, stage1 dest=x5 data=0xBBBB, src0=x5 -> opnd_data0=0xAAAA, opnd_fwd0=1, stall=0.
REQ-038 Stage0 dest=x7 ready=0, src1=x7 valid -> stall=1; next cycle stage1 dest=x7 ready=1 data=0x1234 -> stall=0, opnd_data1=0x1234.
REQ-039 src0=x0, stage0 dest=x0 data=0xFFFF_FFFF -> opnd_data0=0, opnd_fwd0=0, stall=0.
REQ-040 lat_issue rd=x9; src0=x9 for 3 cycles -> stall=1 each cycle; lat_done x9 -> stall=0 the following cycle, stall_cycles=3 plus the done cycle.
REQ-041 lat_issue x4 twice without done -> sb_conflict=1; simultaneous lat_done x4 and lat_issue x4 -> sb_busy[4]=1, no conflict.
REQ-042 Hold a scoreboard stall for MAX_STALL cycles -> deadlock=1; assert rst -> all flags and counters 0 next cycle.
